// File: rtl/mod_down_timer.sv
// Loadable down-counter with pause, abort and optional auto-reload.
// Emits a registered one-cycle done pulse on each expiry.
module mod_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             lv_nz;

  assign lv_nz = |load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Priority: stop > start (non-zero period only) > pause > decrement.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (start && lv_nz) begin
      state_d = RUN;
      count_d = load_val;
    end else begin
      unique case (state_q)
        IDLE: count_d = '0;
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (auto_reload && lv_nz) begin
              count_d = load_val;
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end else if (count_q == '0) begin
            // Unreachable via loads; guards against ever wrapping below zero.
            state_d = DONE;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        PAUSE: if (!pause) state_d = RUN;
        DONE:  count_d = '0;
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = (state_q == RUN) || (state_q == PAUSE);
  assign done  = done_q;

endmodule

// File: doc/mod_down_timer.md
MOD_DOWN_TIMER -- requirements
Module: mod_down_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, synchronous, active-high.
REQ-004 SHALL have port start, input, 1: load load_val and begin counting down.
REQ-005 SHALL have port pause, input, 1, level-sensitive: hold the count while high.
REQ-006 SHALL have port stop, input, 1: abort and return to IDLE.
REQ-007 SHALL have port auto_reload, input, 1: on expiry, reload load_val and keep running.
REQ-008 SHALL have port load_val, input, WIDTH, the period in cycles.
REQ-009 SHALL have port count, output, WIDTH, the registered current count.
REQ-010 SHALL have port state, output, 2, encoded as IDLE=0, RUN=1, PAUSE=2, DONE=3.
REQ-011 SHALL have port busy, output, 1, high when state is RUN or PAUSE; combinational decode of the state register.
REQ-012 SHALL have port done, output, 1, a registered one-cycle expiry pulse.

Function
REQ-013 SHALL evaluate control priority in the order stop > start > pause > decrement in every state.
REQ-014 In IDLE with start=1 and load_val!=0, SHALL set count<=load_val and state<=RUN.
REQ-015 In IDLE with start=1 and load_val==0, SHALL ignore start: remain IDLE with count=0.
REQ-016 In IDLE with any other input combination, SHALL hold count=0.
REQ-017 In RUN with no higher-priority control, SHALL set count<=count-1 each cycle; the first decrement occurs on the edge after the load.
REQ-018 In RUN with count==1, auto_reload=0 and no higher-priority control, SHALL set count<=0, state<=DONE and done<=1.
REQ-019 In RUN with count==1, auto_reload=1 and load_val!=0, SHALL set count<=load_val, remain in RUN and set done<=1, giving a period of exactly load_val cycles.
REQ-020 In RUN with count==1, auto_reload=1 and load_val==0, SHALL behave as REQ-018.
REQ-021 In RUN or PAUSE with start=1, stop=0 and load_val!=0, SHALL restart: count<=load_val, state<=RUN, done stays 0; with load_val==0, start is ignored.
REQ-022 In RUN with pause=1, SHALL set state<=PAUSE and hold count.
REQ-023 In PAUSE with pause=0, SHALL set state<=RUN with no decrement on that edge.
REQ-024 In PAUSE with pause=1, SHALL hold count.
REQ-025 In any state with stop=1, SHALL set state<=IDLE and count<=0 with done=0, even if count==1 on that edge.
REQ-026 In DONE, SHALL hold count=0 until a start per REQ-014/015 rules (leading to RUN) or a stop (leading to IDLE); pause SHALL have no effect in DONE.
REQ-027 SHALL assert done for exactly one cycle per expiry, coincident with the first cycle in which the post-expiry count is visible.
REQ-028 SHALL never underflow: count SHALL never wrap from 0 to 2^WIDTH-1.
REQ-029 SHALL sample load_val only on load and reload edges; changes to load_val at other times SHALL not affect count.

Reset
REQ-030 With rst=1 at a rising edge, SHALL set count=0, state=IDLE and done=0, overriding all other inputs.
REQ-031 Reset mid-RUN or mid-PAUSE SHALL discard the count, with no done pulse.
REQ-032 The first edge after rst deasserts SHALL process inputs normally.

Verification
REQ-033 rst, then start with load_val=3 (WIDTH=4) -> count 3,2,1,0 on successive edges; done=1 only in the cycle showing 0; state DONE; busy falls with DONE.
REQ-034 auto_reload=1, load_val=2, start -> count 2,1,2,1,...; done pulses every 2 cycles, state stays RUN.
REQ-035 start load_val=5, pause for 3 cycles at count=3 -> count holds 3, state PAUSE; after release, 3,2,1,0 with a single done pulse.
REQ-036 stop at count==1 -> IDLE with count 0 and no done pulse; simultaneous stop and start -> IDLE.
REQ-037 start with load_val=0 in IDLE -> remains IDLE; load_val=15 -> 15 cycles to done, no wrap.
REQ-038 rst asserted mid-RUN at count=4 -> next edge gives count 0, IDLE and done=0.
